ysyx_22040759_axi_mem_master: RTL
=================================

Name: ysyx_22040759_axi_mem_master

Overview:
Single-outstanding AXI4 master for the data-memory path. It sits directly downstream of the request dispatcher and consumes its split read channel (mem_rd_*) and write channel (mem_wr_*). Each accepted request becomes one single-beat AXI4 transaction. Completion is returned as one-cycle data-valid pulses, with lane-aligned read data.

Parameters:
ADDR_W, 64, address width on both sides
DATA_W, 64, AXI data width; fixed 64 (8 byte lanes)
ID_W, 4, AXI ID width; all IDs driven 0

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
mem_rd_addr_valid_i  input  1  read request; held high until mem_rd_data_valid_o
mem_rd_addr_i  input  64  read byte address
mem_rd_size_i  input  3  log2 bytes (0=1B..3=8B)
mem_rd_data_valid_o  output  1  one-cycle read-completion pulse
mem_rd_data_o  output  64  read data, right-aligned to bit 0
mem_wr_addr_valid_i  input  1  write request; held high until mem_wr_data_valid_o
mem_wr_addr_i  input  64  write byte address
mem_wr_data_i  input  64  write data, right-aligned
mem_wr_size_i  input  3  log2 bytes
mem_wr_data_valid_o  output  1  one-cycle write-completion pulse
axi_err_o  output  1  one-cycle pulse, coincident with completion, when RRESP/BRESP != 0
axi_ar_valid_o/ready_i  out/in  1  AR handshake
axi_ar_addr_o  output  64  AR address
axi_ar_size_o  output  3  AR size
axi_ar_len_o  output  8  AR length
axi_ar_burst_o  output  2  AR burst
axi_ar_id_o  output  ID_W  AR ID
axi_r_valid_i/ready_o  in/out  1  R handshake
axi_r_data_i  input  64  R data
axi_r_resp_i  input  2  R response
axi_r_last_i  input  1  R last
axi_aw_valid_o/ready_i  out/in  1  AW handshake
axi_aw_addr_o  output  64  AW address
axi_aw_size_o  output  3  AW size
axi_aw_len_o  output  8  AW length
axi_aw_burst_o  output  2  AW burst
axi_aw_id_o  output  ID_W  AW ID
axi_w_valid_o/ready_i  out/in  1  W handshake
axi_w_data_o  output  64  W data
axi_w_strb_o  output  8  W byte strobes
axi_w_last_o  output  1  W last
axi_b_valid_i/ready_o  in/out  1  B handshake
axi_b_resp_i  input  2  B response

Behaviour:
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- Reset: state=IDLE. All valid/ready outputs, completion pulses and axi_err_o are 0. Address, data and strobe registers are 0.
- IDLE: read valid has priority.
  - Read valid: latch addr/size, go to RD_ADDR.
  - Otherwise write valid: latch addr/size/data, go to WR_REQ.
  - Latched values are registered; later input changes are ignored.
- RD_ADDR: ar_valid=1 with the latched values, len=0, burst=2'b01 (INCR), id=0. ar_valid must not drop before ar_ready. On the handshake, go to RD_DATA.
- RD_DATA: r_ready=1. On r_valid, capture:
  - data = r_data >> (8*addr[2:0])
  - err = (r_resp != 0)
  - Then go to DONE with a read flag. r_last is ignored (single beat).
- WR_REQ: aw_valid and w_valid are asserted together.
  - Each deasserts independently after its own handshake, tracked by aw_done/w_done flags.
  - Go to WR_RESP once both are done; this includes the case where both handshake in the same cycle.
  - W data: data << (8*addr[2:0]); w_last=1.
  - W strobe: ((1<<(1<<size))-1) << addr[2:0], truncated to 8 bits.
- WR_RESP: b_ready=1. On b_valid, capture err = (b_resp != 0) and go to DONE with a write flag.
- DONE: lasts exactly one cycle.
  - Assert the matching mem_*_data_valid_o=1, and axi_err_o if err.
  - mem_rd_data_o holds the captured data from DONE until the next read capture.
  - Return to IDLE. Requests are not sampled in DONE, which guarantees no double issue while upstream drops valid.
- Latency with zero-wait slave:
  - Read: request in IDLE at cycle 0 → AR at 1 → R at 2 → pulse at 3.
  - Write: request at 0 → AW/W at 1 → B at 2 → pulse at 3.
- Misaligned size/addr combinations are not checked; the strobe is truncated to 8 lanes.
- Reset asserted mid-transaction returns to IDLE next edge and drops all valid/ready. The outstanding AXI transaction is abandoned; the slave is reset by the same signal.
- Only one transaction is outstanding at a time. The two AXI channel groups are never active simultaneously.

Test Plan:
- Read, addr=0x8000_0004, size=2, zero-wait slave returns r_data=0x1122_3344_5566_7788 → ar_addr=0x8000_0004, ar_size=2, ar_len=0; mem_rd_data_o=0x1122_3344 with a one-cycle pulse at cycle 3.
- Write, addr=0x8000_0003, size=0, data=0xAB → w_strb=0x08, w_data=0xAB000000, w_last=1; one-cycle mem_wr_data_valid_o after B.
- Write with aw_ready delayed 3 cycles and w_ready immediate → w_valid drops after 1 cycle, aw_valid is held 3 cycles, then a single B wait; exactly one completion pulse.
- Read and write valid both high in IDLE → read issued first; write issued after read DONE, provided write valid is still held; no AW activity before the read pulse.
- r_resp=2'b10 on a read → mem_rd_data_valid_o and axi_err_o pulse in the same cycle; FSM returns to IDLE.
- Reset asserted in RD_DATA → next cycle ar_valid=r_ready=0, state IDLE, no completion pulse; a subsequent read completes normally.

Source files
------------

// File: rtl/ysyx_22040759_axi_mem_master.sv
// Single-outstanding AXI4 master for the data-memory path.
// One request in, one single-beat AXI transaction out, one completion pulse back.
module ysyx_22040759_axi_mem_master #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_rd_addr_valid_i,
    input  logic [ADDR_W-1:0] mem_rd_addr_i,
    input  logic [2:0]        mem_rd_size_i,
    output logic              mem_rd_data_valid_o,
    output logic [DATA_W-1:0] mem_rd_data_o,
    input  logic              mem_wr_addr_valid_i,
    input  logic [ADDR_W-1:0] mem_wr_addr_i,
    input  logic [DATA_W-1:0] mem_wr_data_i,
    input  logic [2:0]        mem_wr_size_i,
    output logic              mem_wr_data_valid_o,
    output logic              axi_err_o,
    output logic              axi_ar_valid_o,
    input  logic              axi_ar_ready_i,
    output logic [ADDR_W-1:0] axi_ar_addr_o,
    output logic [2:0]        axi_ar_size_o,
    output logic [7:0]        axi_ar_len_o,
    output logic [1:0]        axi_ar_burst_o,
    output logic [ID_W-1:0]   axi_ar_id_o,
    input  logic              axi_r_valid_i,
    output logic              axi_r_ready_o,
    input  logic [DATA_W-1:0] axi_r_data_i,
    input  logic [1:0]        axi_r_resp_i,
    input  logic              axi_r_last_i,
    output logic              axi_aw_valid_o,
    input  logic              axi_aw_ready_i,
    output logic [ADDR_W-1:0] axi_aw_addr_o,
    output logic [2:0]        axi_aw_size_o,
    output logic [7:0]        axi_aw_len_o,
    output logic [1:0]        axi_aw_burst_o,
    output logic [ID_W-1:0]   axi_aw_id_o,
    output logic              axi_w_valid_o,
    input  logic              axi_w_ready_i,
    output logic [DATA_W-1:0] axi_w_data_o,
    output logic [DATA_W/8-1:0] axi_w_strb_o,
    output logic              axi_w_last_o,
    input  logic              axi_b_valid_i,
    output logic              axi_b_ready_o,
    input  logic [1:0]        axi_b_resp_i
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE
    } state_e;

    state_e state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          size_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic ar_valid_q, r_ready_q, aw_valid_q, w_valid_q, b_ready_q;
    logic aw_done_q, w_done_q, rd_done_q, wr_done_q, err_q;

    logic [DATA_W-1:0]   wdata_d, rdata_d;
    logic [DATA_W/8-1:0] lane_mask, wstrb_d;
    logic aw_hs, w_hs, aw_fin, w_fin;
    logic unused_r_last;

    assign unused_r_last = axi_r_last_i;

    // Lane alignment: write payload moves up to its byte lane, read moves down.
    always_comb begin
        lane_mask = '0;
        if (mem_wr_size_i >= 3'd3)      lane_mask = 8'hFF;
        else if (mem_wr_size_i == 3'd2) lane_mask = 8'h0F;
        else if (mem_wr_size_i == 3'd1) lane_mask = 8'h03;
        else                            lane_mask = 8'h01;
        wstrb_d = lane_mask << mem_wr_addr_i[2:0];
        wdata_d = mem_wr_data_i << {mem_wr_addr_i[2:0], 3'b000};
        rdata_d = axi_r_data_i >> {addr_q[2:0], 3'b000};
    end

    assign aw_hs  = aw_valid_q & axi_aw_ready_i;
    assign w_hs   = w_valid_q & axi_w_ready_i;
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q | w_hs;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wstrb_q    <= '0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rd_done_q  <= 1'b0;
            wr_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
            err_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (mem_rd_addr_valid_i) begin
                        addr_q     <= mem_rd_addr_i;
                        size_q     <= mem_rd_size_i;
                        ar_valid_q <= 1'b1;
                        state_q    <= RD_ADDR;
                    end else if (mem_wr_addr_valid_i) begin
                        addr_q     <= mem_wr_addr_i;
                        size_q     <= mem_wr_size_i;
                        wdata_q    <= wdata_d;
                        wstrb_q    <= wstrb_d;
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                        state_q    <= WR_REQ;
                    end
                end
                RD_ADDR: begin
                    if (axi_ar_ready_i) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi_r_valid_i) begin
                        r_ready_q <= 1'b0;
                        rdata_q   <= rdata_d;
                        err_q     <= |axi_r_resp_i;
                        rd_done_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        aw_valid_q <= 1'b0;
                        aw_done_q  <= 1'b1;
                    end
                    if (w_hs) begin
                        w_valid_q <= 1'b0;
                        w_done_q  <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        b_ready_q <= 1'b1;
                        state_q   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi_b_valid_i) begin
                        b_ready_q <= 1'b0;
                        err_q     <= |axi_b_resp_i;
                        wr_done_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_rd_data_valid_o = rd_done_q;
    assign mem_wr_data_valid_o = wr_done_q;
    assign mem_rd_data_o       = rdata_q;
    assign axi_err_o           = err_q;

    assign axi_ar_valid_o = ar_valid_q;
    assign axi_ar_addr_o  = addr_q;
    assign axi_ar_size_o  = size_q;
    assign axi_ar_len_o   = 8'd0;
    assign axi_ar_burst_o = 2'b01;
    assign axi_ar_id_o    = '0;
    assign axi_r_ready_o  = r_ready_q;

    assign axi_aw_valid_o = aw_valid_q;
    assign axi_aw_addr_o  = addr_q;
    assign axi_aw_size_o  = size_q;
    assign axi_aw_len_o   = 8'd0;
    assign axi_aw_burst_o = 2'b01;
    assign axi_aw_id_o    = '0;
    assign axi_w_valid_o  = w_valid_q;
    assign axi_w_data_o   = wdata_q;
    assign axi_w_strb_o   = wstrb_q;
    assign axi_w_last_o   = 1'b1;
    assign axi_b_ready_o  = b_ready_q;

endmodule
